// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the memory access sequencer: FSM state codes,
// operation encoding and default widths.
package mem_defs;

    localparam int DEF_BITS      = 32;
    localparam int DEF_ADDR_BITS = 9;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM with registered read data; contents are never reset.
module mem_array #(
    parameter int BITS      = 32,
    parameter int ADDR_BITS = 9
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [BITS-1:0]      wdata,
    output logic [BITS-1:0]      rdata
);

    logic [BITS-1:0] mem [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory access sequencer: accepts one read/write from the control unit, waits
// WAIT_STATES cycles, accesses the RAM and hands read data to the MDR.
module mem_access_ctrl
    import mem_defs::*;
#(
    parameter int BITS        = DEF_BITS,
    parameter int ADDR_BITS   = DEF_ADDR_BITS,
    parameter int WAIT_STATES = 2
) (
    input  logic                 clk,
    input  logic                 clear,
    input  logic [ADDR_BITS-1:0] mar_addr,
    input  logic [BITS-1:0]      mdr_data,
    input  logic                 read_req,
    input  logic                 write_req,
    output logic                 ready,
    output logic                 done,
    output logic [BITS-1:0]      mem_data,
    output logic                 mdr_read,
    output logic                 mdr_load,
    output logic                 protocol_err
);

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    logic [1:0]           state_q, state_d;
    logic [3:0]           wait_cnt_q, wait_cnt_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [BITS-1:0]      wdata_q, wdata_d;
    op_e                  op_q, op_d;
    logic [BITS-1:0]      mem_data_q, mem_data_d;
    logic                 done_q, done_d;
    logic                 mdr_rd_q, mdr_rd_d;
    logic                 perr_q, perr_d;

    logic [ADDR_BITS-1:0] ram_addr;
    logic                 ram_we;
    logic [BITS-1:0]      ram_rdata;

    // The RAM sees the incoming address while idle so that its registered read
    // is already valid in ACCESS even with zero wait states.
    assign ram_addr = (state_q == S_IDLE) ? mar_addr : addr_q;
    assign ram_we   = (state_q == S_ACCESS) && (op_q == OP_WRITE);

    mem_array #(
        .BITS      (BITS),
        .ADDR_BITS (ADDR_BITS)
    ) u_mem (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        op_d       = op_q;
        mem_data_d = mem_data_q;
        done_d     = 1'b0;
        mdr_rd_d   = 1'b0;
        perr_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (read_req ^ write_req) begin
                    addr_d     = mar_addr;
                    wdata_d    = mdr_data;
                    op_d       = write_req ? OP_WRITE : OP_READ;
                    wait_cnt_d = WS;
                    state_d    = (WS == 4'd0) ? S_ACCESS : S_WAIT;
                end else if (read_req && write_req) begin
                    perr_d = 1'b1;
                end
            end
            S_WAIT: begin
                wait_cnt_d = wait_cnt_q - 4'd1;
                if (wait_cnt_q == 4'd1) state_d = S_ACCESS;
            end
            S_ACCESS: begin
                state_d = S_DONE;
                done_d  = 1'b1;
                if (op_q == OP_READ) begin
                    mem_data_d = ram_rdata;
                    mdr_rd_d   = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= 4'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            op_q       <= OP_READ;
            mem_data_q <= '0;
            done_q     <= 1'b0;
            mdr_rd_q   <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            op_q       <= op_d;
            mem_data_q <= mem_data_d;
            done_q     <= done_d;
            mdr_rd_q   <= mdr_rd_d;
            perr_q     <= perr_d;
        end
    end

    assign ready        = (state_q == S_IDLE);
    assign done         = done_q;
    assign mem_data     = mem_data_q;
    assign mdr_read     = mdr_rd_q;
    assign mdr_load     = mdr_rd_q;
    assign protocol_err = perr_q;

endmodule
